id_ex_hazard_stage: RTL and testbench

- ID/EX pipeline register for the RV32I 5-stage core, with integrated load-use hazard detection and bubble/flush insertion.
- Captures decode-stage operands and control, and presents registered EX_* signals to the EX-stage ALU and the forwarding unit (EX_Rd_addr, EX_Rs2_addr, EX_RegFile_wr_en, EX_Mem_rd_en).
- Drives the stall that freezes the PC and the IF/ID register.
- Counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_hazard_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register for the RV32I 5-stage core with load-use hazard
// detection, bubble/flush insertion and a saturating bubble counter.
module id_ex_hazard_stage #(
  parameter int REG_DATA_WIDTH     = 32,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int ALU_CTRL_WIDTH     = 4,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          ID_valid,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr,
  input  logic                          ID_Rs1_used,
  input  logic                          ID_Rs2_used,
  input  logic [REG_DATA_WIDTH-1:0]     ID_Rs1_data,
  input  logic [REG_DATA_WIDTH-1:0]     ID_Rs2_data,
  input  logic [REG_DATA_WIDTH-1:0]     ID_Imm,
  input  logic [REG_DATA_WIDTH-1:0]     ID_PC,
  input  logic [1:0]                    ID_ALU_source_sel,
  input  logic [ALU_CTRL_WIDTH-1:0]     ID_ALU_ctrl,
  input  logic                          ID_RegFile_wr_en,
  input  logic                          ID_Mem_rd_en,
  input  logic                          ID_Mem_wr_en,
  input  logic                          EX_Flush,
  input  logic                          Mem_busy,
  output logic                          Stall,
  output logic                          EX_valid,
  output logic [REGFILE_ADDR_WIDTH-1:0] EX_Rs1_addr,
  output logic [REGFILE_ADDR_WIDTH-1:0] EX_Rs2_addr,
  output logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr,
  output logic [REG_DATA_WIDTH-1:0]     EX_Rs1_data,
  output logic [REG_DATA_WIDTH-1:0]     EX_Rs2_data,
  output logic [REG_DATA_WIDTH-1:0]     EX_Imm,
  output logic [REG_DATA_WIDTH-1:0]     EX_PC,
  output logic [1:0]                    EX_ALU_source_sel,
  output logic [ALU_CTRL_WIDTH-1:0]     EX_ALU_ctrl,
  output logic                          EX_RegFile_wr_en,
  output logic                          EX_Mem_rd_en,
  output logic                          EX_Mem_wr_en,
  output logic [CNT_WIDTH-1:0]          Bubble_cnt
);

  typedef struct packed {
    logic                          valid;
    logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr;
    logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr;
    logic [REGFILE_ADDR_WIDTH-1:0] rd_addr;
    logic [REG_DATA_WIDTH-1:0]     rs1_data;
    logic [REG_DATA_WIDTH-1:0]     rs2_data;
    logic [REG_DATA_WIDTH-1:0]     imm;
    logic [REG_DATA_WIDTH-1:0]     pc;
    logic [1:0]                    alu_src_sel;
    logic [ALU_CTRL_WIDTH-1:0]     alu_ctrl;
    logic                          rf_wr_en;
    logic                          mem_rd_en;
    logic                          mem_wr_en;
  } ex_t;

  ex_t                  ex_q, ex_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 load_use;
  logic                 rs1_hit, rs2_hit;

  // A load into x0 writes nothing, so it can never be a hazard source.
  assign rs1_hit  = ID_Rs1_used && (ex_q.rd_addr == ID_Rs1_addr);
  assign rs2_hit  = ID_Rs2_used && (ex_q.rd_addr == ID_Rs2_addr);
  assign load_use = ex_q.valid && ex_q.mem_rd_en && (ex_q.rd_addr != '0) &&
                    ID_valid && (rs1_hit || rs2_hit);
  assign Stall    = (load_use && !EX_Flush) || Mem_busy;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (Mem_busy) begin
      ex_d  = ex_q;
    end else if (EX_Flush) begin
      ex_d  = '0;
    end else if (load_use) begin
      ex_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      ex_d.valid       = ID_valid;
      ex_d.rs1_addr    = ID_Rs1_addr;
      ex_d.rs2_addr    = ID_Rs2_addr;
      ex_d.rd_addr     = ID_Rd_addr;
      ex_d.rs1_data    = ID_Rs1_data;
      ex_d.rs2_data    = ID_Rs2_data;
      ex_d.imm         = ID_Imm;
      ex_d.pc          = ID_PC;
      ex_d.alu_src_sel = ID_ALU_source_sel;
      ex_d.alu_ctrl    = ID_ALU_ctrl;
      // Control enables of an empty decode slot must not reach EX.
      ex_d.rf_wr_en    = ID_valid && ID_RegFile_wr_en;
      ex_d.mem_rd_en   = ID_valid && ID_Mem_rd_en;
      ex_d.mem_wr_en   = ID_valid && ID_Mem_wr_en;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign EX_valid          = ex_q.valid;
  assign EX_Rs1_addr       = ex_q.rs1_addr;
  assign EX_Rs2_addr       = ex_q.rs2_addr;
  assign EX_Rd_addr        = ex_q.rd_addr;
  assign EX_Rs1_data       = ex_q.rs1_data;
  assign EX_Rs2_data       = ex_q.rs2_data;
  assign EX_Imm            = ex_q.imm;
  assign EX_PC             = ex_q.pc;
  assign EX_ALU_source_sel = ex_q.alu_src_sel;
  assign EX_ALU_ctrl       = ex_q.alu_ctrl;
  assign EX_RegFile_wr_en  = ex_q.rf_wr_en;
  assign EX_Mem_rd_en      = ex_q.mem_rd_en;
  assign EX_Mem_wr_en      = ex_q.mem_wr_en;
  assign Bubble_cnt        = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage; a second instance with a 2-bit
// counter exercises counter saturation within a short run.
module tb_id_ex_hazard_stage;
  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        ID_valid, ID_Rs1_used, ID_Rs2_used;
  logic [4:0]  ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr;
  logic [31:0] ID_Rs1_data, ID_Rs2_data, ID_Imm, ID_PC;
  logic [1:0]  ID_ALU_source_sel;
  logic [3:0]  ID_ALU_ctrl;
  logic        ID_RegFile_wr_en, ID_Mem_rd_en, ID_Mem_wr_en;
  logic        EX_Flush, Mem_busy;

  logic        Stall, EX_valid;
  logic [4:0]  EX_Rs1_addr, EX_Rs2_addr, EX_Rd_addr;
  logic [31:0] EX_Rs1_data, EX_Rs2_data, EX_Imm, EX_PC;
  logic [1:0]  EX_ALU_source_sel;
  logic [3:0]  EX_ALU_ctrl;
  logic        EX_RegFile_wr_en, EX_Mem_rd_en, EX_Mem_wr_en;
  logic [15:0] Bubble_cnt;

  logic        s_Stall, s_EX_valid;
  logic [4:0]  s_EX_Rs1_addr, s_EX_Rs2_addr, s_EX_Rd_addr;
  logic [31:0] s_EX_Rs1_data, s_EX_Rs2_data, s_EX_Imm, s_EX_PC;
  logic [1:0]  s_EX_ALU_source_sel;
  logic [3:0]  s_EX_ALU_ctrl;
  logic        s_EX_RegFile_wr_en, s_EX_Mem_rd_en, s_EX_Mem_wr_en;
  logic [1:0]  s_Bubble_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  id_ex_hazard_stage dut (
    .Clk(Clk), .Reset_n(Reset_n), .ID_valid(ID_valid),
    .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr), .ID_Rd_addr(ID_Rd_addr),
    .ID_Rs1_used(ID_Rs1_used), .ID_Rs2_used(ID_Rs2_used),
    .ID_Rs1_data(ID_Rs1_data), .ID_Rs2_data(ID_Rs2_data), .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .ID_ALU_source_sel(ID_ALU_source_sel), .ID_ALU_ctrl(ID_ALU_ctrl),
    .ID_RegFile_wr_en(ID_RegFile_wr_en), .ID_Mem_rd_en(ID_Mem_rd_en), .ID_Mem_wr_en(ID_Mem_wr_en),
    .EX_Flush(EX_Flush), .Mem_busy(Mem_busy), .Stall(Stall), .EX_valid(EX_valid),
    .EX_Rs1_addr(EX_Rs1_addr), .EX_Rs2_addr(EX_Rs2_addr), .EX_Rd_addr(EX_Rd_addr),
    .EX_Rs1_data(EX_Rs1_data), .EX_Rs2_data(EX_Rs2_data), .EX_Imm(EX_Imm), .EX_PC(EX_PC),
    .EX_ALU_source_sel(EX_ALU_source_sel), .EX_ALU_ctrl(EX_ALU_ctrl),
    .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_wr_en(EX_Mem_wr_en),
    .Bubble_cnt(Bubble_cnt)
  );

  id_ex_hazard_stage #(.CNT_WIDTH(2)) u_sat (
    .Clk(Clk), .Reset_n(Reset_n), .ID_valid(ID_valid),
    .ID_Rs1_addr(ID_Rs1_addr), .ID_Rs2_addr(ID_Rs2_addr), .ID_Rd_addr(ID_Rd_addr),
    .ID_Rs1_used(ID_Rs1_used), .ID_Rs2_used(ID_Rs2_used),
    .ID_Rs1_data(ID_Rs1_data), .ID_Rs2_data(ID_Rs2_data), .ID_Imm(ID_Imm), .ID_PC(ID_PC),
    .ID_ALU_source_sel(ID_ALU_source_sel), .ID_ALU_ctrl(ID_ALU_ctrl),
    .ID_RegFile_wr_en(ID_RegFile_wr_en), .ID_Mem_rd_en(ID_Mem_rd_en), .ID_Mem_wr_en(ID_Mem_wr_en),
    .EX_Flush(EX_Flush), .Mem_busy(Mem_busy), .Stall(s_Stall), .EX_valid(s_EX_valid),
    .EX_Rs1_addr(s_EX_Rs1_addr), .EX_Rs2_addr(s_EX_Rs2_addr), .EX_Rd_addr(s_EX_Rd_addr),
    .EX_Rs1_data(s_EX_Rs1_data), .EX_Rs2_data(s_EX_Rs2_data), .EX_Imm(s_EX_Imm), .EX_PC(s_EX_PC),
    .EX_ALU_source_sel(s_EX_ALU_source_sel), .EX_ALU_ctrl(s_EX_ALU_ctrl),
    .EX_RegFile_wr_en(s_EX_RegFile_wr_en), .EX_Mem_rd_en(s_EX_Mem_rd_en), .EX_Mem_wr_en(s_EX_Mem_wr_en),
    .Bubble_cnt(s_Bubble_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Drive one decode-slot instruction; data/imm/pc are derived from the fields.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic wr, input logic st);
    ID_valid          = v;
    ID_Rs1_addr       = rs1;  ID_Rs1_used = u1;
    ID_Rs2_addr       = rs2;  ID_Rs2_used = u2;
    ID_Rd_addr        = rd;
    ID_Rs1_data       = 32'hA000_0000 | {27'd0, rs1};
    ID_Rs2_data       = 32'hB000_0000 | {27'd0, rs2};
    ID_Imm            = 32'hFFFF_F000 | {27'd0, rd};
    ID_PC             = 32'h0000_4000 + {27'd0, rd};
    ID_ALU_source_sel = 2'b00;
    ID_ALU_ctrl       = 4'h0;
    ID_Mem_rd_en      = ld;
    ID_RegFile_wr_en  = wr;
    ID_Mem_wr_en      = st;
  endtask

  initial begin
    Reset_n  = 1'b0;
    EX_Flush = 1'b0;
    Mem_busy = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_valid", {31'd0, EX_valid}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_cnt", {16'd0, Bubble_cnt}, 32'd0);
    tick();
    Reset_n = 1'b1;

    // Pass-through: add x5, x1, x2
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
    ID_Rs1_data = 32'h11; ID_Rs2_data = 32'h22;
    ID_ALU_source_sel = 2'b01; ID_ALU_ctrl = 4'h3;
    #1 chk("pt_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("pt_valid", {31'd0, EX_valid}, 32'd1);
    chk("pt_rd", {27'd0, EX_Rd_addr}, 32'd5);
    chk("pt_rs1_data", EX_Rs1_data, 32'h11);
    chk("pt_rs2_data", EX_Rs2_data, 32'h22);
    chk("pt_imm", EX_Imm, 32'hFFFF_F005);
    chk("pt_pc", EX_PC, 32'h0000_4005);
    chk("pt_src_sel", {30'd0, EX_ALU_source_sel}, 32'd1);
    chk("pt_ctrl", {28'd0, EX_ALU_ctrl}, 32'd3);
    chk("pt_wr_en", {31'd0, EX_RegFile_wr_en}, 32'd1);
    chk("pt_stall_after", {31'd0, Stall}, 32'd0);

    // Load-use: lw x7 then add x8, x7, x2
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    chk("lu_ld_in_ex", {31'd0, EX_Mem_rd_en}, 32'd1);
    drive(1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, EX_valid}, 32'd0);
    chk("lu_bub_wr", {31'd0, EX_RegFile_wr_en}, 32'd0);
    chk("lu_bub_rd", {27'd0, EX_Rd_addr}, 32'd0);
    chk("lu_bub_data", EX_Rs1_data, 32'd0);
    chk("lu_cnt", {16'd0, Bubble_cnt}, 32'd1);
    chk("lu_stall_drop", {31'd0, Stall}, 32'd0);
    tick();
    chk("lu_add_rd", {27'd0, EX_Rd_addr}, 32'd8);
    chk("lu_add_rs1", {27'd0, EX_Rs1_addr}, 32'd7);
    chk("lu_add_valid", {31'd0, EX_valid}, 32'd1);
    chk("lu_cnt_hold", {16'd0, Bubble_cnt}, 32'd1);

    // lw x0 then a read of x0: no hazard
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    #1 chk("x0_stall", {31'd0, Stall}, 32'd0);
    tick();
    chk("x0_captured", {27'd0, EX_Rd_addr}, 32'd9);

    // lw x7 then addi whose rs2 field is 7 but unused
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0);
    #1 chk("unused_rs2_stall", {31'd0, Stall}, 32'd0);

    // Flush coincident with load-use (lw x7 still in EX)
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
    EX_Flush = 1'b1;
    #1 chk("fl_stall", {31'd0, Stall}, 32'd0);
    tick();
    EX_Flush = 1'b0;
    chk("fl_bub_valid", {31'd0, EX_valid}, 32'd0);
    chk("fl_bub_rd", {27'd0, EX_Rd_addr}, 32'd0);
    chk("fl_cnt", {16'd0, Bubble_cnt}, 32'd1);

    // Mem_busy freezes EX for 3 edges
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0);
    Mem_busy = 1'b1;
    #1 chk("mb_stall", {31'd0, Stall}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mb_hold_rd", {27'd0, EX_Rd_addr}, 32'd7);
      chk("mb_hold_ld", {31'd0, EX_Mem_rd_en}, 32'd1);
      chk("mb_stall_hold", {31'd0, Stall}, 32'd1);
    end
    chk("mb_cnt", {16'd0, Bubble_cnt}, 32'd1);
    Mem_busy = 1'b0;
    #1 chk("mb_stall_drop", {31'd0, Stall}, 32'd0);
    tick();
    chk("mb_release_rd", {27'd0, EX_Rd_addr}, 32'd10);
    chk("mb_release_ld", {31'd0, EX_Mem_rd_en}, 32'd0);

    // Empty decode slot: enables gated off, fields still captured
    drive(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b1, 1'b1);
    tick();
    chk("gate_valid", {31'd0, EX_valid}, 32'd0);
    chk("gate_wr", {31'd0, EX_RegFile_wr_en}, 32'd0);
    chk("gate_ld", {31'd0, EX_Mem_rd_en}, 32'd0);
    chk("gate_st", {31'd0, EX_Mem_wr_en}, 32'd0);
    chk("gate_rd", {27'd0, EX_Rd_addr}, 32'd12);

    // Back-to-back loads: lw x7; lw x11, 0(x7) -> exactly one bubble
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
    #1 chk("b2b_stall", {31'd0, Stall}, 32'd1);
    tick();
    chk("b2b_bubble", {31'd0, EX_valid}, 32'd0);
    chk("b2b_cnt", {16'd0, Bubble_cnt}, 32'd2);
    chk("b2b_stall_drop", {31'd0, Stall}, 32'd0);
    tick();
    chk("b2b_rd", {27'd0, EX_Rd_addr}, 32'd11);
    chk("b2b_ld", {31'd0, EX_Mem_rd_en}, 32'd1);
    chk("b2b_sat_cnt", {30'd0, s_Bubble_cnt}, 32'd2);

    // Three more load-use events: 2-bit counter saturates at 3
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
      #1 chk("sat_stall", {31'd0, Stall}, 32'd1);
      tick();
      tick();
      chk("sat_small", {30'd0, s_Bubble_cnt}, 32'd3);
      chk("sat_main", {16'd0, Bubble_cnt}, 32'(3 + i));
    end

    // Asynchronous reset while stalled on a load-use
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
    #1 chk("mr_pre_stall", {31'd0, Stall}, 32'd1);
    chk("mr_pre_ld", {31'd0, EX_Mem_rd_en}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, EX_valid}, 32'd0);
    chk("mr_ld", {31'd0, EX_Mem_rd_en}, 32'd0);
    chk("mr_rd", {27'd0, EX_Rd_addr}, 32'd0);
    chk("mr_wr", {31'd0, EX_RegFile_wr_en}, 32'd0);
    chk("mr_stall", {31'd0, Stall}, 32'd0);
    chk("mr_cnt", {16'd0, Bubble_cnt}, 32'd0);
    chk("mr_sat_cnt", {30'd0, s_Bubble_cnt}, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
